// File: rtl/pll_lock_sequencer_if.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer_if
// Groups the PLL control/status signals shared by the lock sequencer and its
// surroundings (PLL macro plus downstream reset logic).
//   pll_locked   PLL lock indication, asynchronous to the sequencer clock
//   force_reset  1-cycle request to restart the lock sequence
//   pll_rst      PLL reset, active high
//   ready        PLL locked and qualified
//   fault        retries exhausted
//   lock_lost    1-cycle pulse when lock drops while running
//   retry_cnt    timeouts seen in the current sequence
//   loss_cnt     saturating count of lock losses while running
// Modports: master = sequencer side, slave = PLL/system side.
// -----------------------------------------------------------------------------
interface pll_lock_sequencer_if;
    logic       pll_locked;
    logic       force_reset;
    logic       pll_rst;
    logic       ready;
    logic       fault;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    modport master (
        input  pll_locked,
        input  force_reset,
        output pll_rst,
        output ready,
        output fault,
        output lock_lost,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_locked,
        output force_reset,
        input  pll_rst,
        input  ready,
        input  fault,
        input  lock_lost,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
// Owns the system PLL reset/lock handshake on the reference clock: pulses the
// PLL reset, waits for lock under a timeout, qualifies lock as stable, then
// raises ready. Retries a bounded number of times before parking in FAULT and
// re-sequences when lock is lost while running.
// Ports:
//   clk    reference clock (same net as the PLL refclk)
//   rst_n  asynchronous active-low reset
//   bus    pll_lock_sequencer_if.master (pll_locked/force_reset in; pll_rst,
//          ready, fault, lock_lost, retry_cnt, loss_cnt out)
// All outputs are registered or decoded from the state register.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_lock_sequencer_if.master   bus
);
    localparam int RST_W = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
    localparam int STB_W = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
    localparam int TMO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t           state_reg,     state_next;
    logic [RST_W-1:0] rst_cnt_reg,   rst_cnt_next;
    logic [STB_W-1:0] stb_cnt_reg,   stb_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg,   tmo_cnt_next;
    logic [3:0]       retry_reg,     retry_next;
    logic [7:0]       loss_reg,      loss_next;
    logic             lock_lost_reg, lock_lost_next;
    logic [1:0]       sync_reg;
    logic             locked_s;
    logic             timeout;

    // Two-flop synchroniser for the asynchronous lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], bus.pll_locked};
        end
    end

    assign locked_s = sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RESET;
            rst_cnt_reg   <= '0;
            stb_cnt_reg   <= '0;
            tmo_cnt_reg   <= '0;
            retry_reg     <= '0;
            loss_reg      <= '0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            stb_cnt_reg   <= stb_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    // The timeout window spans WAIT_LOCK and STABLE together; a lock that
    // bounces does not buy more time.
    assign timeout = (tmo_cnt_reg == TMO_LAST);

    always_comb begin
        state_next     = state_reg;
        rst_cnt_next   = rst_cnt_reg;
        stb_cnt_next   = stb_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        retry_next     = retry_reg;
        loss_next      = loss_reg;
        lock_lost_next = 1'b0;

        case (state_reg)
            ST_RESET: begin
                if (rst_cnt_reg == RST_LAST) begin
                    state_next   = ST_WAIT_LOCK;
                    rst_cnt_next = '0;
                    tmo_cnt_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg + RST_W'(1);
                end
            end

            ST_WAIT_LOCK, ST_STABLE: begin
                if (timeout) begin
                    // Timeout wins over a same-cycle STABLE->RUN qualification.
                    tmo_cnt_next = '0;
                    stb_cnt_next = '0;
                    if (retry_reg == RETRY_MAX) begin
                        state_next = ST_FAULT;
                    end else begin
                        retry_next   = retry_reg + 4'd1;
                        rst_cnt_next = '0;
                        state_next   = ST_RESET;
                    end
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                    if (state_reg == ST_WAIT_LOCK) begin
                        if (locked_s) begin
                            state_next   = ST_STABLE;
                            stb_cnt_next = '0;
                        end
                    end else if (!locked_s) begin
                        state_next   = ST_WAIT_LOCK;
                        stb_cnt_next = '0;
                    end else if (stb_cnt_reg == STB_LAST) begin
                        state_next = ST_RUN;
                        retry_next = '0;
                    end else begin
                        stb_cnt_next = stb_cnt_reg + STB_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_next     = ST_RESET;
                    rst_cnt_next   = '0;
                    lock_lost_next = 1'b1;
                    loss_next      = (loss_reg == 8'hFF) ? loss_reg : loss_reg + 8'd1;
                end
            end

            ST_FAULT: begin
                // Parked until force_reset or rst_n.
            end

            default: begin
                state_next   = ST_RESET;
                rst_cnt_next = '0;
            end
        endcase

        // force_reset overrides everything, including a same-cycle lock loss;
        // loss_cnt is a lifetime statistic and is left alone.
        if (bus.force_reset) begin
            state_next     = ST_RESET;
            rst_cnt_next   = '0;
            stb_cnt_next   = '0;
            tmo_cnt_next   = '0;
            retry_next     = '0;
            lock_lost_next = 1'b0;
            loss_next      = loss_reg;
        end
    end

    assign bus.pll_rst   = (state_reg == ST_RESET) || (state_reg == ST_FAULT);
    assign bus.ready     = (state_reg == ST_RUN);
    assign bus.fault     = (state_reg == ST_FAULT);
    assign bus.lock_lost = lock_lost_reg;
    assign bus.retry_cnt = retry_reg;
    assign bus.loss_cnt  = loss_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
// Self-checking bench for pll_lock_sequencer with small parameters.
// Expected output vectors {pll_rst, ready, fault, lock_lost, retry_cnt,
// loss_cnt} are queued against the cycle index at which they must appear and
// compared when the run reaches that cycle. Cycle 0 is the first clk edge
// with rst_n high; outputs for cycle k are sampled on the falling edge just
// before edge k.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int MAX_RETRY    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int          grp;
        int          cyc;
        logic [15:0] vec;
        string       name;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mode_g = 1;   // 0: locked low, 1: locked high, 2: toggle every 5, 3: manual

    function automatic logic [15:0] ov(input bit r, input bit rd, input bit f,
                                       input bit ll, input int rt, input int ls);
        return {r, rd, f, ll, 4'(rt), 8'(ls)};
    endfunction

    function automatic logic [15:0] act();
        return {bus.pll_rst, bus.ready, bus.fault, bus.lock_lost, bus.retry_cnt, bus.loss_cnt};
    endfunction

    task automatic add(input int g, input int c, input logic [15:0] v, input string n);
        vec_t e;
        e.grp = g; e.cyc = c; e.vec = v; e.name = n;
        tbl.push_back(e);
    endtask

    task automatic expect_at(input int c, input logic [15:0] v, input string n);
        vec_t e;
        e.grp = -1; e.cyc = c; e.vec = v; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string n, input int c, input logic [15:0] e);
        logic [15:0] a;
        a = act();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got rst=%b rdy=%b flt=%b ll=%b retry=%0d loss=%0d expected rst=%b rdy=%b flt=%b ll=%b retry=%0d loss=%0d",
                     n, c, a[15], a[14], a[13], a[12], a[11:8], a[7:0],
                     e[15], e[14], e[13], e[12], e[11:8], e[7:0]);
        end else begin
            $display("ok   %s cyc=%0d rst=%b rdy=%b flt=%b ll=%b retry=%0d loss=%0d",
                     n, c, a[15], a[14], a[13], a[12], a[11:8], a[7:0]);
        end
    endtask

    task automatic check_due();
        vec_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: cycle %0d passed unsampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                cmp(e.name, cyc, e.vec);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (mode_g == 2) bus.pll_locked = ((cyc / 5) % 2) == 1;
        checks++;
        if (bus.ready && bus.fault) begin
            errors++;
            $display("FAIL ready_fault_excl cyc=%0d got ready=1 fault=1 required not both", cyc);
        end
        check_due();
    endtask

    task automatic run_until(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 2000) begin
            step();
            guard++;
        end
        if (cyc < n) begin
            checks++;
            errors++;
            $display("FAIL run_until: reached cycle %0d, required %0d", cyc, n);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            step();
            guard++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Holds rst_n low, applies the locked mode, releases on a falling edge
    // and checks any cycle-0 expectations.
    task automatic do_reset(input int mode);
        rst_n           = 1'b0;
        bus.force_reset = 1'b0;
        mode_g          = mode;
        bus.pll_locked  = (mode == 1 || mode == 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_due();
    endtask

    initial begin
        bus.pll_locked  = 1'b0;
        bus.force_reset = 1'b0;

        // Group 1: lock present from the start.
        add(1,  0, ov(1,0,0,0,0,0), "lk_reset_c0");
        add(1,  3, ov(1,0,0,0,0,0), "lk_reset_c3");
        add(1,  4, ov(0,0,0,0,0,0), "lk_wait_c4");
        add(1, 12, ov(0,0,0,0,0,0), "lk_stable_last");
        add(1, 13, ov(0,1,0,0,0,0), "lk_ready_c13");
        add(1, 20, ov(0,1,0,0,0,0), "lk_ready_hold");
        // Groups 0 and 2: never qualifies; timeouts, retries, then FAULT.
        for (int g = 0; g <= 2; g += 2) begin
            add(g,   0, ov(1,0,0,0,0,0), "nl_pulse0");
            add(g,   3, ov(1,0,0,0,0,0), "nl_pulse0_end");
            add(g,   4, ov(0,0,0,0,0,0), "nl_wait0");
            add(g,  35, ov(0,0,0,0,0,0), "nl_tmo0_last");
            add(g,  36, ov(1,0,0,0,1,0), "nl_pulse1");
            add(g,  39, ov(1,0,0,0,1,0), "nl_pulse1_end");
            add(g,  40, ov(0,0,0,0,1,0), "nl_wait1");
            add(g,  71, ov(0,0,0,0,1,0), "nl_tmo1_last");
            add(g,  72, ov(1,0,0,0,2,0), "nl_pulse2");
            add(g,  76, ov(0,0,0,0,2,0), "nl_wait2");
            add(g, 107, ov(0,0,0,0,2,0), "nl_tmo2_last");
            add(g, 108, ov(1,0,1,0,2,0), "nl_fault");
            add(g, 120, ov(1,0,1,0,2,0), "nl_fault_hold");
        end

        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < tbl.size(); i++)
                if (tbl[i].grp == g) exp_q.push_back(tbl[i]);
            do_reset(g);
            drain();
        end

        // Lock drop while running, then relock; finish with async reset mid-RUN.
        expect_at(22, ov(0,1,0,0,0,0), "loss_run_before");
        expect_at(23, ov(1,0,0,1,0,1), "loss_pulse");
        expect_at(24, ov(1,0,0,0,0,1), "loss_pulse_end");
        expect_at(26, ov(1,0,0,0,0,1), "loss_reset_end");
        expect_at(27, ov(0,0,0,0,0,1), "loss_wait");
        expect_at(35, ov(0,0,0,0,0,1), "loss_stable_last");
        expect_at(36, ov(0,1,0,0,0,1), "loss_relocked");
        do_reset(3);
        run_until(20);
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        drain();
        run_until(40);
        rst_n = 1'b0;
        #1;
        cmp("async_rst_run", cyc, ov(1,0,0,0,0,0));

        // Async reset mid-STABLE.
        expect_at(8, ov(0,0,0,0,0,0), "stable_c8");
        do_reset(1);
        run_until(8);
        rst_n = 1'b0;
        #1;
        cmp("async_rst_stable", cyc, ov(1,0,0,0,0,0));

        // FAULT recovery through force_reset.
        expect_at(108, ov(1,0,1,0,2,0), "fr_fault");
        expect_at(115, ov(1,0,1,0,2,0), "fr_fault_pre");
        expect_at(116, ov(1,0,0,0,0,0), "fr_cleared");
        expect_at(119, ov(1,0,0,0,0,0), "fr_reset_end");
        expect_at(120, ov(0,0,0,0,0,0), "fr_wait");
        expect_at(128, ov(0,0,0,0,0,0), "fr_stable_last");
        expect_at(129, ov(0,1,0,0,0,0), "fr_ready");
        do_reset(0);
        run_until(110);
        mode_g         = 3;
        bus.pll_locked = 1'b1;
        run_until(115);
        bus.force_reset = 1'b1;
        step();
        bus.force_reset = 1'b0;
        drain();

        // force_reset coincident with lock loss, then force_reset mid-RESET.
        expect_at(22, ov(0,1,0,0,0,0), "co_run");
        expect_at(23, ov(1,0,0,0,0,0), "co_no_pulse");
        expect_at(24, ov(1,0,0,0,0,0), "co_no_pulse2");
        expect_at(26, ov(1,0,0,0,0,0), "co_restart");
        expect_at(27, ov(1,0,0,0,0,0), "co_restart_hold");
        expect_at(29, ov(1,0,0,0,0,0), "co_restart_end");
        expect_at(30, ov(0,0,0,0,0,0), "co_wait");
        expect_at(38, ov(0,0,0,0,0,0), "co_stable_last");
        expect_at(39, ov(0,1,0,0,0,0), "co_ready");
        do_reset(3);
        run_until(20);
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        step();
        bus.force_reset = 1'b1;
        step();
        bus.force_reset = 1'b0;
        run_until(25);
        bus.force_reset = 1'b1;
        step();
        bus.force_reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
